// File: rtl/serial_compare_sequencer.sv
// Sequences a parallel operand pair through an MSB-first sticky serial compare and
// returns a one-hot lt/eq/gt result. Optional early exit: SERIAL_CMP_EARLY_EXIT_EN.
module serial_compare_sequencer #(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             ser_valid,
    output logic             ser_a,
    output logic             ser_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_lt,
    output logic             out_eq,
    output logic             out_gt,
    output logic [CNT_W-1:0] out_bits
);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} ctl_t;
    typedef enum logic [1:0] {C_EQ, C_LT, C_GT} cmp_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH);

    ctl_t             r_state, w_state_nxt;
    cmp_t             r_cmp, w_cmp_nxt;
    logic [WIDTH-1:0] r_sa, r_sb;
    logic [CNT_W-1:0] r_cnt, w_cnt_inc;
    logic             w_msb_a, w_msb_b;

    assign w_msb_a   = r_sa[WIDTH-1];
    assign w_msb_b   = r_sb[WIDTH-1];
    assign w_cnt_inc = r_cnt + 1'b1;

    always_comb begin
        w_cmp_nxt = r_cmp;
        if (r_cmp == C_EQ) begin
            if (w_msb_a & ~w_msb_b)
                w_cmp_nxt = C_GT;
            else if (~w_msb_a & w_msb_b)
                w_cmp_nxt = C_LT;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (in_valid) w_state_nxt = S_SHIFT;
            S_SHIFT: begin
                if (w_cnt_inc == LAST)
                    w_state_nxt = S_DONE;
`ifdef SERIAL_CMP_EARLY_EXIT_EN
                else if (w_cmp_nxt != C_EQ)
                    w_state_nxt = S_DONE;
`endif
            end
            S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cmp   <= C_EQ;
            r_sa    <= '0;
            r_sb    <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: if (in_valid) begin
                    r_sa  <= in_a;
                    r_sb  <= in_b;
                    r_cmp <= C_EQ;
                    r_cnt <= '0;
                end
                S_SHIFT: begin
                    r_cmp <= w_cmp_nxt;
                    r_sa  <= r_sa << 1;
                    r_sb  <= r_sb << 1;
                    r_cnt <= w_cnt_inc;
                end
                default: ;
            endcase
        end
    end

    // Outputs are masked by rst because reset only takes effect at the next edge.
    always_comb begin
        in_ready  = ~rst & (r_state == S_IDLE);
        ser_valid = ~rst & (r_state == S_SHIFT);
        out_valid = ~rst & (r_state == S_DONE);
        ser_a     = ser_valid & w_msb_a;
        ser_b     = ser_valid & w_msb_b;
        out_lt    = out_valid & (r_cmp == C_LT);
        out_eq    = out_valid & (r_cmp == C_EQ);
        out_gt    = out_valid & (r_cmp == C_GT);
        out_bits  = out_valid ? r_cnt : '0;
    end

endmodule

// File: tb/tb_serial_compare_sequencer.sv
// Directed plus random bench for serial_compare_sequencer (WIDTH=8 and WIDTH=1 instances).
module tb_serial_compare_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, out_ready;
    logic [7:0] in_a, in_b;
    logic       in_ready, ser_valid, ser_a, ser_b, out_valid, out_lt, out_eq, out_gt;
    logic [3:0] out_bits;

    logic       w1_in_valid, w1_out_ready, w1_in_a, w1_in_b;
    logic       w1_in_ready, w1_ser_valid, w1_ser_a, w1_ser_b, w1_out_valid;
    logic       w1_out_lt, w1_out_eq, w1_out_gt, w1_out_bits;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    serial_compare_sequencer #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .ser_valid(ser_valid), .ser_a(ser_a), .ser_b(ser_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_lt(out_lt), .out_eq(out_eq),
        .out_gt(out_gt), .out_bits(out_bits)
    );

    serial_compare_sequencer #(.WIDTH(1)) u1 (
        .clk(clk), .rst(rst), .in_valid(w1_in_valid), .in_ready(w1_in_ready),
        .in_a(w1_in_a), .in_b(w1_in_b), .ser_valid(w1_ser_valid), .ser_a(w1_ser_a),
        .ser_b(w1_ser_b), .out_valid(w1_out_valid), .out_ready(w1_out_ready),
        .out_lt(w1_out_lt), .out_eq(w1_out_eq), .out_gt(w1_out_gt), .out_bits(w1_out_bits)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: number of bit pairs examined, from the position of the first difference.
    function automatic int exp_bits(input logic [7:0] a, input logic [7:0] b);
`ifdef SERIAL_CMP_EARLY_EXIT_EN
        for (int i = 7; i >= 0; i--)
            if (a[i] != b[i]) return 8 - i;
`endif
        return 8;
    endfunction

    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int hold);
        int n;
        int bits;
        bit lt, eq, gt;
        lt   = (a < b);
        eq   = (a == b);
        gt   = (a > b);
        bits = exp_bits(a, b);
        n    = 0;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("accept_ready", 32'(in_ready), 32'd1);
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        in_a     = 8'($urandom);
        in_b     = 8'($urandom);
        for (int k = 1; k <= bits; k++) begin
            if (k > 1) @(negedge clk);
            chk("ser_valid", 32'(ser_valid), 32'd1);
            chk("ser_a", 32'(ser_a), 32'(a[8-k]));
            chk("ser_b", 32'(ser_b), 32'(b[8-k]));
            chk("shift_out_valid", 32'(out_valid), 32'd0);
            chk("shift_in_ready", 32'(in_ready), 32'd0);
        end
        for (int h = 0; h <= hold; h++) begin
            @(negedge clk);
            chk("done_valid", 32'(out_valid), 32'd1);
            chk("done_onehot", 32'({out_lt, out_eq, out_gt}), 32'({lt, eq, gt}));
            chk("done_bits", 32'(out_bits), 32'(bits));
            chk("done_ser_valid", 32'(ser_valid), 32'd0);
            chk("done_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("post_out_valid", 32'(out_valid), 32'd0);
        chk("post_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; out_ready = 1'b0; in_a = '0; in_b = '0;
        w1_in_valid = 1'b0; w1_out_ready = 1'b0; w1_in_a = 1'b0; w1_in_b = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_ser_valid", 32'(ser_valid), 32'd0);
        chk("rst_result", 32'({out_lt, out_eq, out_gt, out_bits}), 32'd0);
        chk("rst_w1_in_ready", 32'(w1_in_ready), 32'd0);
        rst = 1'b0;
        #1;
        chk("rel_in_ready", 32'(in_ready), 32'd1);
        chk("rel_w1_in_ready", 32'(w1_in_ready), 32'd1);

        run_op(8'h5A, 8'h5A, 0);
        run_op(8'h80, 8'h7F, 0);
        run_op(8'h12, 8'h13, 0);
        run_op(8'hF0, 8'h0F, 5);
        run_op(8'h00, 8'hFF, 1);
        run_op(8'hFF, 8'hFE, 0);

        // Reset in the third SHIFT cycle discards the operation.
        @(negedge clk);
        in_a = 8'h3C; in_b = 8'hC3; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("mid_ser_valid", 32'(ser_valid), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_ser_valid", 32'(ser_valid), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_rel_in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("mid_no_out_valid", 32'(out_valid), 32'd0);
        end
        run_op(8'h01, 8'h02, 0);

        for (int i = 0; i < 25; i++) begin
            logic [7:0] ra, rb;
            ra = 8'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? ra : 8'($urandom);
            run_op(ra, rb, int'($urandom_range(0, 3)));
        end

        @(negedge clk);
        w1_in_a = 1'b1; w1_in_b = 1'b0; w1_in_valid = 1'b1;
        @(negedge clk);
        w1_in_valid = 1'b0;
        chk("w1_ser_valid", 32'(w1_ser_valid), 32'd1);
        chk("w1_ser_bits", 32'({w1_ser_a, w1_ser_b}), 32'b10);
        chk("w1_early_valid", 32'(w1_out_valid), 32'd0);
        @(negedge clk);
        chk("w1_out_valid", 32'(w1_out_valid), 32'd1);
        chk("w1_onehot", 32'({w1_out_lt, w1_out_eq, w1_out_gt}), 32'b001);
        chk("w1_bits", 32'(w1_out_bits), 32'd1);
        w1_out_ready = 1'b1;
        @(negedge clk);
        w1_out_ready = 1'b0;
        chk("w1_post_valid", 32'(w1_out_valid), 32'd0);
        chk("w1_post_ready", 32'(w1_in_ready), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
